// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with a valid/ready result stage and an
// XOR accumulator (op 111) that folds beats into one result per frame.
module bitwise_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             first,
  input  logic             last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_parity,
  output logic             acc_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acc_state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_out_zero;
  logic             r_out_parity;

  logic             w_accept;
  logic             w_load;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_logic_res;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_acc_new;
  logic [WIDTH-1:0] w_res;

  // Handshake: a beat moves on any edge where in_valid && in_ready; a result
  // moves on any edge where out_valid && out_ready. in_ready depends only on
  // the output stage, so a held result blocks input and a draining one frees
  // the slot in the same cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_logic_res = '0;
    unique case (op)
      OP_AND:  w_logic_res = a & b;
      OP_OR:   w_logic_res = a | b;
      OP_XOR:  w_logic_res = a ^ b;
      OP_XNOR: w_logic_res = ~(a ^ b);
      OP_NAND: w_logic_res = ~(a & b);
      OP_NOR:  w_logic_res = ~(a | b);
      OP_NOTA: w_logic_res = ~a;
      OP_ACC:  w_logic_res = '0;
      default: w_logic_res = '0;
    endcase
  end

  // A frame starts from zero when none is open or when first restarts it.
  assign w_acc_base = ((r_state == ST_IDLE) || first) ? '0 : r_acc;
  assign w_acc_new  = w_acc_base ^ a ^ b;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_load      = 1'b0;
    w_res       = w_logic_res;
    if (w_accept) begin
      if (op == OP_ACC) begin
        if (last) begin
          w_load      = 1'b1;
          w_res       = w_acc_new;
          w_acc_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_acc_nxt   = w_acc_new;
          w_state_nxt = ST_RUN;
        end
      end else begin
        w_load = 1'b1;
      end
    end
    w_valid_nxt = w_load ? 1'b1 : (r_out_valid && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_out_zero   <= 1'b0;
      r_out_parity <= 1'b0;
    end else begin
      r_out_valid <= w_valid_nxt;
      if (w_load) begin
        r_out        <= w_res;
        r_out_zero   <= ~|w_res;
        r_out_parity <= ^w_res;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out        = r_out;
  assign out_zero   = r_out_zero;
  assign out_parity = r_out_parity;
  assign acc_busy   = (r_state == ST_RUN);

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed and randomized checks of bitwise_logic_unit (WIDTH=8 and WIDTH=4)
// against a behavioural model with an expected-result queue.
module tb_bitwise_logic_unit;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, first, last, out_ready;
  logic       out_valid, out_zero, out_parity, acc_busy;
  logic [7:0] a, b, out;
  logic [2:0] op;

  logic       in_valid_4, in_ready_4, out_valid_4, out_zero_4, out_parity_4, acc_busy_4;
  logic [3:0] a_4, b_4, out_4;
  logic [2:0] op_4;

  int n_checks;
  int n_errors;

  logic [7:0] exp_q[$];

  bitwise_logic_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .first(first), .last(last), .out_ready(out_ready),
    .out_valid(out_valid), .out(out), .out_zero(out_zero),
    .out_parity(out_parity), .acc_busy(acc_busy)
  );

  bitwise_logic_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .op(op_4), .first(1'b0), .last(1'b0), .out_ready(1'b1),
    .out_valid(out_valid_4), .out(out_4), .out_zero(out_zero_4),
    .out_parity(out_parity_4), .acc_busy(acc_busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input int code, input logic [7:0] x, input logic [7:0] y);
    case (code)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x ^ y);
      4: return ~(x & y);
      5: return ~(x | y);
      default: return ~x;
    endcase
  endfunction

  task automatic beat(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic f, input logic l);
    op = o; a = x; b = y; first = f; last = l; in_valid = 1'b1;
  endtask

  initial begin
    logic       m_valid, m_open, exp_rdy;
    logic [7:0] m_acc, base, nv, got;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; first = 1'b0; last = 1'b0;
    in_valid_4 = 1'b0; a_4 = '0; b_4 = '0; op_4 = '0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_zero", out_zero, 0);
    check("rst_parity", out_parity, 0);
    check("rst_busy", acc_busy, 0);
    check("rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;

    // XOR
    beat(3'b010, 8'hA5, 8'h3C, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("xor_valid", out_valid, 1);
    check("xor_out", out, 8'h99);
    check("xor_zero", out_zero, 0);
    check("xor_parity", out_parity, 0);
    step();
    check("xor_drained", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    beat(3'b000, 8'hF0, 8'h0F, 1'b0, 1'b0);
    step();
    beat(3'b001, 8'h01, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, 8'h00);
      check("bp_zero", out_zero, 1);
      check("bp_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_out", out, 8'h03);
    check("bp_second_zero", out_zero, 0);
    step();
    check("bp_drained", out_valid, 0);

    // Accumulate frame
    beat(3'b111, 8'h12, 8'h34, 1'b1, 1'b0);
    step();
    check("acc1_valid", out_valid, 0);
    check("acc1_busy", acc_busy, 1);
    beat(3'b111, 8'h56, 8'h00, 1'b0, 1'b0);
    step();
    check("acc2_valid", out_valid, 0);
    check("acc2_busy", acc_busy, 1);
    beat(3'b111, 8'hFF, 8'h01, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("acc3_valid", out_valid, 1);
    check("acc3_out", out, 8'h8E);
    check("acc3_parity", out_parity, 0);
    check("acc3_busy", acc_busy, 0);
    step();

    // Interleaved logic op inside a frame
    beat(3'b111, 8'h12, 8'h34, 1'b1, 1'b0);
    step();
    beat(3'b111, 8'h56, 8'h00, 1'b0, 1'b0);
    step();
    beat(3'b011, 8'h0F, 8'hF0, 1'b0, 1'b0);
    step();
    check("il_valid", out_valid, 1);
    check("il_out", out, 8'h00);
    check("il_zero", out_zero, 1);
    check("il_busy", acc_busy, 1);
    beat(3'b111, 8'hFF, 8'h01, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("il_frame_out", out, 8'h8E);
    check("il_frame_valid", out_valid, 1);
    check("il_frame_busy", acc_busy, 0);
    step();

    // Reset mid-frame, with a result also pending
    beat(3'b111, 8'h11, 8'h22, 1'b1, 1'b0);
    step();
    beat(3'b001, 8'h40, 8'h00, 1'b0, 1'b0);
    step();
    beat(3'b111, 8'h33, 8'h44, 1'b0, 1'b0);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("mid_busy_before", acc_busy, 1);
    check("mid_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", acc_busy, 0);
    check("mid_rst_out", out, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(3'b111, 8'h0F, 8'h00, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("post_rst_out", out, 8'h0F);
    check("post_rst_parity", out_parity, 0);
    check("post_rst_valid", out_valid, 1);
    step();

    // WIDTH=4 instance
    in_valid_4 = 1'b1; op_4 = 3'b110; a_4 = 4'h3; b_4 = 4'h9;
    step();
    check("w4_nota", out_4, 4'hC);
    check("w4_nota_valid", out_valid_4, 1);
    op_4 = 3'b101; a_4 = 4'h0; b_4 = 4'h0;
    step();
    in_valid_4 = 1'b0;
    check("w4_nor", out_4, 4'hF);
    check("w4_nor_parity", out_parity_4, 0);
    check("w4_busy", acc_busy_4, 0);

    // Randomized traffic against the model
    m_valid = 1'b0; m_open = 1'b0; m_acc = '0;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      a         = 8'($urandom);
      b         = 8'($urandom);
      first     = ($urandom_range(0, 4) == 0);
      last      = ($urandom_range(0, 3) == 0);
      #1;
      exp_rdy = !m_valid || out_ready;
      check("rnd_in_ready", in_ready, exp_rdy);
      check("rnd_out_valid", out_valid, m_valid);
      check("rnd_busy", acc_busy, m_open);
      if (m_valid) begin
        got = exp_q[0];
        check("rnd_out", out, got);
        check("rnd_zero", out_zero, (got == 0));
        check("rnd_parity", out_parity, $countones(got) % 2);
        if (out_ready) begin
          void'(exp_q.pop_front());
          m_valid = 1'b0;
        end
      end
      if (in_valid && exp_rdy) begin
        if (op != 3'b111) begin
          exp_q.push_back(ref_op(int'(op), a, b));
          m_valid = 1'b1;
        end else begin
          base = (!m_open || first) ? 8'h00 : m_acc;
          nv = base ^ a ^ b;
          if (last) begin
            exp_q.push_back(nv);
            m_valid = 1'b1;
            m_acc = '0;
            m_open = 1'b0;
          end else begin
            m_acc = nv;
            m_open = 1'b1;
          end
        end
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("rnd_drain_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
